// File: rtl/priv_trap_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : priv_trap_sequencer_if
// Purpose  : Request/response bundle between the hazard unit / CSR file and
//            the privilege trap sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface priv_trap_sequencer_if #(
    parameter int WORD_W = 32
);
    logic [8:0]        exc_req;
    logic              exc_is_store;
    logic [1:0]        env_priv;
    logic [2:0]        int_pend;
    logic              int_gen;
    logic              mret;
    logic              sret;
    logic              wfi;
    logic              ex_mem_stall;
    logic              pipe_clear;
    logic [WORD_W-1:0] epc;
    logic [WORD_W-1:0] badaddr;
    logic [WORD_W-1:0] mtvec;
    logic [WORD_W-1:0] mepc;
    logic [WORD_W-1:0] sepc;

    logic              insert_pc;
    logic [WORD_W-1:0] priv_pc;
    logic              intr;
    logic              trap_commit;
    logic              ret_commit;
    logic              ret_is_s;
    logic [WORD_W-1:0] cause;
    logic [WORD_W-1:0] tval;
    logic [WORD_W-1:0] trap_epc;
    logic              wfi_sleep;

    modport master (
        output exc_req, exc_is_store, env_priv, int_pend, int_gen,
               mret, sret, wfi, ex_mem_stall, pipe_clear,
               epc, badaddr, mtvec, mepc, sepc,
        input  insert_pc, priv_pc, intr, trap_commit, ret_commit,
               ret_is_s, cause, tval, trap_epc, wfi_sleep
    );

    modport slave (
        input  exc_req, exc_is_store, env_priv, int_pend, int_gen,
               mret, sret, wfi, ex_mem_stall, pipe_clear,
               epc, badaddr, mtvec, mepc, sepc,
        output insert_pc, priv_pc, intr, trap_commit, ret_commit,
               ret_is_s, cause, tval, trap_epc, wfi_sleep
    );
endinterface
`default_nettype wire

// File: rtl/priv_trap_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : priv_trap_sequencer
// Purpose  : Prioritises traps/xRET/WFI, drains the pipeline, then issues a
//            one-cycle PC redirect with CSR commit strobes.
//            Optional macro PRIV_VECTORED_TRAP_EN enables vectored interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module priv_trap_sequencer #(
    parameter int WORD_W    = 32,
    parameter int DRAIN_MAX = 31
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    priv_trap_sequencer_if.slave bus
);
    localparam int c_cnt_w = $clog2(DRAIN_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_INSERT = 2'd2,
        ST_SLEEP  = 2'd3
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt,      w_cnt_nxt;
    logic [WORD_W-1:0]   r_cause,    w_cause_nxt;
    logic [WORD_W-1:0]   r_tval,     w_tval_nxt;
    logic [WORD_W-1:0]   r_epc,      w_epc_nxt;
    logic [WORD_W-1:0]   r_target,   w_target_nxt;
    logic                r_is_trap,  w_is_trap_nxt;
    logic                r_ret_is_s, w_ret_is_s_nxt;

    logic [4:0]          w_exc_code;
    logic [4:0]          w_int_code;
    logic [WORD_W-1:0]   w_base;
    logic [WORD_W-1:0]   w_int_target;
    logic [WORD_W-1:0]   w_int_cause;

    // Lowest-numbered request bit wins; bits 6-8 split on load/store.
    always_comb begin
        w_exc_code = 5'd0;
        if (bus.exc_req[0])      w_exc_code = 5'd3;
        else if (bus.exc_req[1]) w_exc_code = 5'd12;
        else if (bus.exc_req[2]) w_exc_code = 5'd1;
        else if (bus.exc_req[3]) w_exc_code = 5'd2;
        else if (bus.exc_req[4]) w_exc_code = 5'd0;
        else if (bus.exc_req[5]) w_exc_code = 5'd8 + {3'b000, bus.env_priv};
        else if (bus.exc_req[6]) w_exc_code = bus.exc_is_store ? 5'd6  : 5'd4;
        else if (bus.exc_req[7]) w_exc_code = bus.exc_is_store ? 5'd15 : 5'd13;
        else if (bus.exc_req[8]) w_exc_code = bus.exc_is_store ? 5'd7  : 5'd5;
    end

    always_comb begin
        w_int_code = 5'd7;
        if (bus.int_pend[2])      w_int_code = 5'd11;
        else if (bus.int_pend[0]) w_int_code = 5'd3;
    end

    assign w_base      = {bus.mtvec[WORD_W-1:2], 2'b00};
    assign w_int_cause = {1'b1, {(WORD_W-6){1'b0}}, w_int_code};

`ifdef PRIV_VECTORED_TRAP_EN
    assign w_int_target = (bus.mtvec[1:0] == 2'b01)
                        ? w_base + {{(WORD_W-7){1'b0}}, w_int_code, 2'b00}
                        : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = &{1'b0, bus.mtvec[1:0]};
    assign w_int_target  = w_base;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cause    <= '0;
            r_tval     <= '0;
            r_epc      <= '0;
            r_target   <= '0;
            r_is_trap  <= 1'b0;
            r_ret_is_s <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cause    <= w_cause_nxt;
            r_tval     <= w_tval_nxt;
            r_epc      <= w_epc_nxt;
            r_target   <= w_target_nxt;
            r_is_trap  <= w_is_trap_nxt;
            r_ret_is_s <= w_ret_is_s_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cause_nxt    = r_cause;
        w_tval_nxt     = r_tval;
        w_epc_nxt      = r_epc;
        w_target_nxt   = r_target;
        w_is_trap_nxt  = r_is_trap;
        w_ret_is_s_nxt = r_ret_is_s;
        case (r_state)
            ST_IDLE: begin
                if (!bus.ex_mem_stall) begin
                    if (|bus.exc_req) begin
                        w_cause_nxt    = {{(WORD_W-5){1'b0}}, w_exc_code};
                        w_tval_nxt     = bus.badaddr;
                        w_epc_nxt      = bus.epc;
                        w_target_nxt   = w_base;
                        w_is_trap_nxt  = 1'b1;
                        w_ret_is_s_nxt = 1'b0;
                        w_state_nxt    = ST_DRAIN;
                    end else if (bus.int_gen && (|bus.int_pend)) begin
                        w_cause_nxt    = w_int_cause;
                        w_tval_nxt     = '0;
                        w_epc_nxt      = bus.epc;
                        w_target_nxt   = w_int_target;
                        w_is_trap_nxt  = 1'b1;
                        w_ret_is_s_nxt = 1'b0;
                        w_state_nxt    = ST_DRAIN;
                    end else if (bus.mret) begin
                        w_target_nxt   = bus.mepc;
                        w_is_trap_nxt  = 1'b0;
                        w_ret_is_s_nxt = 1'b0;
                        w_state_nxt    = ST_DRAIN;
                    end else if (bus.sret) begin
                        w_target_nxt   = bus.sepc;
                        w_is_trap_nxt  = 1'b0;
                        w_ret_is_s_nxt = 1'b1;
                        w_state_nxt    = ST_DRAIN;
                    end else if (bus.wfi) begin
                        w_state_nxt    = ST_SLEEP;
                    end
                end
            end
            ST_DRAIN: begin
                // The count at exit equals the number of DRAIN cycles spent.
                w_cnt_nxt = r_cnt + 1'b1;
                if (bus.pipe_clear || (r_cnt == c_cnt_w'(DRAIN_MAX - 1))) begin
                    w_state_nxt = ST_INSERT;
                end
            end
            ST_INSERT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            ST_SLEEP: begin
                // Wake ignores the global enable; only taking the trap needs it.
                if (|bus.int_pend) begin
                    if (bus.int_gen) begin
                        w_cause_nxt    = w_int_cause;
                        w_tval_nxt     = '0;
                        w_epc_nxt      = bus.epc;
                        w_target_nxt   = w_int_target;
                        w_is_trap_nxt  = 1'b1;
                        w_ret_is_s_nxt = 1'b0;
                        w_state_nxt    = ST_DRAIN;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.intr        = (r_state == ST_DRAIN) || (r_state == ST_INSERT);
    assign bus.insert_pc   = (r_state == ST_INSERT);
    assign bus.trap_commit = (r_state == ST_INSERT) && r_is_trap;
    assign bus.ret_commit  = (r_state == ST_INSERT) && !r_is_trap;
    assign bus.ret_is_s    = (r_state == ST_INSERT) && !r_is_trap && r_ret_is_s;
    assign bus.wfi_sleep   = (r_state == ST_SLEEP);
    assign bus.priv_pc     = r_target;
    assign bus.cause       = r_cause;
    assign bus.tval        = r_tval;
    assign bus.trap_epc    = r_epc;
endmodule
`default_nettype wire

// File: tb/tb_priv_trap_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_priv_trap_sequencer
// Purpose  : Self-checking bench: directed vector table, WFI/reset sequences
//            and randomized requests against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priv_trap_sequencer;
    localparam int W    = 32;
    localparam int DMAX = 31;
    localparam logic [31:0] M0 = 32'h8000_0000;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    priv_trap_sequencer_if #(.WORD_W(W)) bus();

    priv_trap_sequencer #(.WORD_W(W), .DRAIN_MAX(DMAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8:0]  exc;
        logic [2:0]  pend;
        logic        gen, mret, sret, stall, store;
        logic [1:0]  env;
        logic [31:0] epc, bad, mtvec, mepc, sepc;
        int          dl;
    } req_t;

    typedef struct {
        logic        any, trap, is_s;
        logic [31:0] cause, tval, pc;
        int          lat;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic req_t mk(input logic [8:0] exc, input logic [2:0] pend, input logic gen,
                                input logic mr, input logic sr, input logic st, input logic [1:0] env,
                                input logic [31:0] epc, input logic [31:0] bad,
                                input logic [31:0] mtvec, input int dl);
        req_t r;
        r = '{exc: exc, pend: pend, gen: gen, mret: mr, sret: sr, stall: 1'b0, store: st,
              env: env, epc: epc, bad: bad, mtvec: mtvec, mepc: 32'h8000_0200,
              sepc: 32'h8000_0300, dl: dl};
        return r;
    endfunction

    function automatic exp_t ex(input logic trap, input logic is_s, input logic [31:0] cause,
                                input logic [31:0] tval, input logic [31:0] pc, input int lat);
        exp_t e;
        e = '{any: 1'b1, trap: trap, is_s: is_s, cause: cause, tval: tval, pc: pc, lat: lat};
        return e;
    endfunction

    // Reference model: code tables indexed by request bit, priority by scan order.
    function automatic exp_t model(input req_t r);
        exp_t        e;
        int unsigned load_code [9];
        int unsigned store_code[9];
        int unsigned code;
        logic [31:0] base;
        load_code  = '{3, 12, 1, 2, 0, 8, 4, 13, 5};
        store_code = '{3, 12, 1, 2, 0, 8, 6, 15, 7};
        e = '{any: 1'b0, trap: 1'b0, is_s: 1'b0, cause: '0, tval: '0, pc: '0, lat: 0};
        e.lat = ((r.dl < 1) ? 1 : ((r.dl > DMAX) ? DMAX : r.dl)) + 1;
        base  = r.mtvec & ~32'h3;
        code  = 0;
        if (r.stall) return e;
        if (r.exc != 9'h0) begin
            for (int i = 8; i >= 0; i--) begin
                if (r.exc[i]) code = r.store ? store_code[i] : load_code[i];
            end
            if (r.exc[4:0] == 5'h0 && r.exc[5]) code = 8 + int'(r.env);
            e.any = 1'b1; e.trap = 1'b1; e.cause = code; e.tval = r.bad; e.pc = base;
        end else if (r.gen && r.pend != 3'b000) begin
            code = r.pend[2] ? 11 : (r.pend[0] ? 3 : 7);
            e.any = 1'b1; e.trap = 1'b1; e.cause = 32'h8000_0000 + code; e.tval = 0; e.pc = base;
`ifdef PRIV_VECTORED_TRAP_EN
            if (r.mtvec[1:0] == 2'b01) e.pc = base + 4 * code;
`endif
        end else if (r.mret) begin
            e.any = 1'b1; e.pc = r.mepc;
        end else if (r.sret) begin
            e.any = 1'b1; e.is_s = 1'b1; e.pc = r.sepc;
        end
        return e;
    endfunction

    task automatic apply(input string nm, input req_t r, input exp_t e);
        int lat;
        lat = 0;
        bus.exc_req = r.exc;   bus.int_pend = r.pend;   bus.int_gen = r.gen;
        bus.mret = r.mret;     bus.sret = r.sret;       bus.wfi = 1'b0;
        bus.ex_mem_stall = r.stall; bus.exc_is_store = r.store; bus.env_priv = r.env;
        bus.epc = r.epc;       bus.badaddr = r.bad;     bus.mtvec = r.mtvec;
        bus.mepc = r.mepc;     bus.sepc = r.sepc;       bus.pipe_clear = (r.dl == 0);
        tick();
        // Scramble the sources so any unlatched path shows up at the redirect.
        bus.exc_req = '0; bus.int_pend = '0; bus.mret = 1'b0; bus.sret = 1'b0;
        bus.ex_mem_stall = 1'b0;
        bus.epc = $urandom; bus.badaddr = $urandom; bus.mtvec = $urandom;
        bus.mepc = $urandom; bus.sepc = $urandom;
        if (!e.any) begin
            check({nm, " no_action"}, {bus.intr, bus.insert_pc, bus.wfi_sleep}, 0);
            bus.pipe_clear = 1'b1;
            return;
        end
        check({nm, " intr_drain"}, bus.intr, 1);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (bus.insert_pc) lat = k;
            else begin
                bus.pipe_clear = (k >= r.dl);
                tick();
            end
        end
        check({nm, " latency"}, lat, e.lat);
        if (lat != 0) begin
            check({nm, " priv_pc"}, bus.priv_pc, e.pc);
            check({nm, " commits"}, {bus.intr, bus.trap_commit, bus.ret_commit, bus.ret_is_s},
                  {1'b1, e.trap, !e.trap, e.is_s});
            if (e.trap) begin
                check({nm, " cause"}, bus.cause, e.cause);
                check({nm, " tval"}, bus.tval, e.tval);
                check({nm, " epc"}, bus.trap_epc, r.epc);
            end
            tick();
            check({nm, " pulse_end"}, {bus.insert_pc, bus.intr, bus.trap_commit, bus.ret_commit}, 0);
        end
        bus.pipe_clear = 1'b1;
    endtask

    task automatic sleep_seq(input string nm, input logic gen);
        int slept;
        slept = 0;
        bus.wfi = 1'b1; bus.int_gen = gen; bus.mtvec = M0; bus.epc = 32'h8000_0400;
        tick();
        bus.wfi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.wfi_sleep && !bus.intr) slept++;
            tick();
        end
        check({nm, " sleep_cycles"}, slept, 10);
        bus.int_pend = 3'b010;
        tick();
        bus.int_pend = 3'b000;
        if (!gen) begin
            check({nm, " wake_idle"}, {bus.wfi_sleep, bus.intr, bus.insert_pc}, 0);
            tick();
            check({nm, " no_redirect"}, {bus.intr, bus.insert_pc, bus.trap_commit}, 0);
        end else begin
            check({nm, " wake_drain"}, {bus.wfi_sleep, bus.intr}, 2'b01);
            tick();
            check({nm, " insert"}, {bus.insert_pc, bus.trap_commit}, 2'b11);
            check({nm, " cause"}, bus.cause, 32'h8000_0007);
            check({nm, " tval"}, bus.tval, 0);
            check({nm, " priv_pc"}, bus.priv_pc, M0);
            tick();
        end
        bus.int_gen = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.exc_req = '0; bus.exc_is_store = 1'b0; bus.env_priv = '0; bus.int_pend = '0;
        bus.int_gen = 1'b0; bus.mret = 1'b0; bus.sret = 1'b0; bus.wfi = 1'b0;
        bus.ex_mem_stall = 1'b0; bus.pipe_clear = 1'b1; bus.epc = '0; bus.badaddr = '0;
        bus.mtvec = M0; bus.mepc = '0; bus.sepc = '0;

        vecs[0]  = '{mk(9'h008, 3'b000, 0, 0, 0, 0, 0, 32'h8000_0100, 32'h13, M0, 0),
                     ex(1, 0, 32'h2, 32'h13, M0, 2)};
        vecs[1]  = '{mk(9'h101, 3'b000, 0, 0, 0, 0, 0, 32'h8000_0104, 32'h44, M0, 0),
                     ex(1, 0, 32'h3, 32'h44, M0, 2)};
        vecs[2]  = '{mk(9'h000, 3'b110, 1, 0, 0, 0, 0, 32'h8000_0108, 32'hdead, M0, 0),
                     ex(1, 0, 32'h8000_000B, 32'h0, M0, 2)};
        vecs[3]  = '{mk(9'h000, 3'b000, 0, 1, 0, 0, 0, 32'h0, 32'h0, M0, 3),
                     ex(0, 0, 32'h0, 32'h0, 32'h8000_0200, 4)};
        vecs[4]  = '{mk(9'h000, 3'b000, 0, 0, 1, 0, 0, 32'h0, 32'h0, M0, 1),
                     ex(0, 1, 32'h0, 32'h0, 32'h8000_0300, 2)};
        vecs[5]  = '{mk(9'h020, 3'b000, 0, 0, 0, 0, 3, 32'h8000_0110, 32'h77, 32'h8000_0003, 0),
                     ex(1, 0, 32'd11, 32'h77, M0, 2)};
        vecs[6]  = '{mk(9'h0C0, 3'b000, 0, 0, 0, 1, 0, 32'h8000_0114, 32'h1001, M0, 0),
                     ex(1, 0, 32'd6, 32'h1001, M0, 2)};
        vecs[7]  = '{mk(9'h180, 3'b000, 0, 0, 0, 0, 0, 32'h8000_0118, 32'h2000, M0, 0),
                     ex(1, 0, 32'd13, 32'h2000, M0, 2)};
        vecs[8]  = '{mk(9'h010, 3'b000, 0, 1, 0, 0, 0, 32'h8000_011C, 32'h3, M0, 0),
                     ex(1, 0, 32'd0, 32'h3, M0, 2)};
        vecs[9]  = '{mk(9'h000, 3'b001, 0, 0, 1, 0, 0, 32'h0, 32'h0, M0, 0),
                     ex(0, 1, 32'h0, 32'h0, 32'h8000_0300, 2)};
        vecs[10] = '{mk(9'h004, 3'b000, 0, 0, 0, 0, 0, 32'h8000_0120, 32'h8000_0120, M0, 40),
                     ex(1, 0, 32'd1, 32'h8000_0120, M0, 32)};
`ifdef PRIV_VECTORED_TRAP_EN
        vecs[11] = '{mk(9'h000, 3'b010, 1, 0, 0, 0, 0, 32'h8000_0124, 32'h5, 32'h8000_0001, 0),
                     ex(1, 0, 32'h8000_0007, 32'h0, 32'h8000_001C, 2)};
        vecs[12] = '{mk(9'h000, 3'b001, 1, 0, 0, 0, 0, 32'h8000_0128, 32'h5, 32'h8000_0001, 0),
                     ex(1, 0, 32'h8000_0003, 32'h0, 32'h8000_000C, 2)};
`else
        vecs[11] = '{mk(9'h000, 3'b010, 1, 0, 0, 0, 0, 32'h8000_0124, 32'h5, 32'h8000_0001, 0),
                     ex(1, 0, 32'h8000_0007, 32'h0, M0, 2)};
        vecs[12] = '{mk(9'h000, 3'b001, 1, 0, 0, 0, 0, 32'h8000_0128, 32'h5, 32'h8000_0001, 0),
                     ex(1, 0, 32'h8000_0003, 32'h0, M0, 2)};
`endif
        vecs[13] = '{mk(9'h008, 3'b000, 0, 0, 0, 0, 0, 32'h8000_012C, 32'h9, M0, 0),
                     ex(0, 0, 32'h0, 32'h0, 32'h0, 0)};
        vecs[13].r.stall = 1'b1;
        vecs[13].e.any   = 1'b0;
        vecs[14] = '{mk(9'h060, 3'b000, 0, 0, 0, 1, 0, 32'h8000_0130, 32'hA, M0, 0),
                     ex(1, 0, 32'd8, 32'hA, M0, 2)};
        vecs[15] = '{mk(9'h100, 3'b000, 0, 0, 0, 1, 0, 32'h8000_0134, 32'hB, M0, 2),
                     ex(1, 0, 32'd7, 32'hB, M0, 3)};

        tick();
        tick();
        check("reset strobes", {bus.intr, bus.insert_pc, bus.trap_commit, bus.ret_commit,
                                bus.ret_is_s, bus.wfi_sleep}, 0);
        check("reset priv_pc", bus.priv_pc, 0);
        check("reset cause_tval", {bus.cause, bus.tval}, 0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), vecs[i].r, vecs[i].e);

        sleep_seq("wfi_gen0", 1'b0);
        sleep_seq("wfi_gen1", 1'b1);

        // Reset in the middle of DRAIN drops the half-finished trap.
        bus.exc_req = 9'h008; bus.badaddr = 32'h55; bus.mtvec = M0; bus.pipe_clear = 1'b0;
        tick();
        bus.exc_req = '0;
        tick();
        tick();
        check("rst_mid intr_before", bus.intr, 1);
        #2 RST = 1'b1;
        #1;
        check("rst_mid strobes", {bus.intr, bus.insert_pc, bus.trap_commit, bus.ret_commit,
                                  bus.wfi_sleep}, 0);
        check("rst_mid regs", {bus.cause, bus.tval, bus.priv_pc}, 0);
        tick();
        RST = 1'b0;
        bus.pipe_clear = 1'b1;
        tick();
        tick();
        check("rst_mid discarded", {bus.intr, bus.insert_pc, bus.trap_commit}, 0);

        for (int n = 0; n < 80; n++) begin
            req_t r;
            int   sel;
            r.exc   = ($urandom_range(0, 2) == 0) ? 9'($urandom) : 9'h0;
            r.pend  = 3'($urandom);
            r.gen   = 1'($urandom);
            r.mret  = ($urandom_range(0, 3) == 0);
            r.sret  = ($urandom_range(0, 3) == 0);
            r.stall = ($urandom_range(0, 7) == 0);
            r.store = 1'($urandom);
            sel     = $urandom_range(0, 2);
            r.env   = (sel == 2) ? 2'd3 : 2'(sel);
            r.epc   = $urandom; r.bad  = $urandom; r.mtvec = $urandom;
            r.mepc  = $urandom; r.sepc = $urandom;
            r.dl    = ($urandom_range(0, 9) == 0) ? 35 : $urandom_range(0, 5);
            apply($sformatf("rand%0d", n), r, model(r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
